// File: rtl/sc_fir_pkg.sv
// Shared defaults, FSM state encoding and run-length helper for the
// stochastic weighted adder.
package sc_fir_pkg;

  localparam int unsigned SC_N_DEFAULT    = 12;
  localparam int unsigned SC_TAPS_DEFAULT = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

  // Number of accumulate cycles in one run.
  function automatic int unsigned sc_run_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/sc_cdf_select.sv
// Tap selector: picks the lowest tap whose cumulative-weight threshold
// exceeds the selection random number; falls back to the last tap.
module sc_cdf_select
  import sc_fir_pkg::*;
#(
  parameter int unsigned TAPS = SC_TAPS_DEFAULT,
  parameter int unsigned N    = SC_N_DEFAULT,
  parameter int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic [TAPS-1:0][N-1:0] cdf_i,
  input  logic [N-1:0]           rng_sel_i,
  output logic [AW-1:0]          tap_c_o
);

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    tap_c_o = AW'(TAPS - 1);
    for (int i = int'(TAPS) - 1; i >= 0; i--) begin
      if (rng_sel_i < cdf_i[i]) begin
        tap_c_o = AW'(i);
      end
    end
  end

endmodule

// File: rtl/sc_wadd_param.sv
// Stochastic-computing weighted adder: each run of 2^N cycles picks one tap
// per cycle by its cumulative weight and counts that tap's stochastic bit.
// Optional feature macro: SC_SIGN_EN builds per-tap negation storage.
module sc_wadd_param
  import sc_fir_pkg::*;
#(
  parameter int unsigned N    = SC_N_DEFAULT,
  parameter int unsigned TAPS = SC_TAPS_DEFAULT,
  parameter int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [TAPS-1:0][N-1:0] in_i,
  input  logic [N-1:0]           rng_y_i,
  input  logic [N-1:0]           rng_sel_i,
  input  logic                   cfg_we_i,
  input  logic [AW-1:0]          cfg_addr_i,
  input  logic [N-1:0]           cfg_cdf_i,
  input  logic                   cfg_sign_i,
  output logic [N:0]             out_o,
  output logic                   done_o,
  output logic                   busy_o
);

  localparam int unsigned CW      = N + 1;
  localparam logic [CW-1:0] RUN_LEN = CW'(sc_run_len(N));

  sc_state_e              state_q, state_d;
  logic [CW-1:0]          out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TAPS-1:0][N-1:0] cdf_q, cdf_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [TAPS-1:0]        sn_c;
  logic [TAPS-1:0]        xb_c;
  logic [AW-1:0]          tap_c;
  logic                   xb_sel_c;
  logic                   cfg_ok_c;

`ifdef SC_SIGN_EN
  logic [TAPS-1:0]        sign_q, sign_d;
`else
  logic                   unused_cfg_sign;
  assign unused_cfg_sign = cfg_sign_i;
`endif

  // Per-tap stochastic bit: binary value compared against the shared random.
  always_comb begin
    for (int i = 0; i < int'(TAPS); i++) begin
      sn_c[i] = (in_i[i] > rng_y_i);
    end
  end

  // Optional per-tap negation.
  always_comb begin
`ifdef SC_SIGN_EN
    xb_c = sn_c ^ sign_q;
`else
    xb_c = sn_c;
`endif
  end

  sc_cdf_select #(
    .TAPS (TAPS),
    .N    (N),
    .AW   (AW)
  ) u_sel (
    .cdf_i     (cdf_q),
    .rng_sel_i (rng_sel_i),
    .tap_c_o   (tap_c)
  );

  assign xb_sel_c = xb_c[tap_c];
  assign cfg_ok_c = cfg_we_i && (state_q != RUN);

  // Next-state, accumulator, run counter and weight-table update.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    cdf_d   = cdf_q;
`ifdef SC_SIGN_EN
    sign_d  = sign_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          out_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (start_i) begin
          out_d = '0;
          cnt_d = '0;
        end else if (cnt_q == RUN_LEN) begin
          state_d = DONE;
        end else begin
          out_d = out_q + CW'(xb_sel_c);
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (start_i) begin
          state_d = RUN;
          out_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Table writes only outside a run; out-of-range addresses match nothing.
    if (cfg_ok_c) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        if (cfg_addr_i == AW'(i)) begin
          cdf_d[i]  = cfg_cdf_i;
`ifdef SC_SIGN_EN
          sign_d[i] = cfg_sign_i;
`endif
        end
      end
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      cdf_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SC_SIGN_EN
      sign_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      cdf_q   <= cdf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SC_SIGN_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign out_o  = out_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: doc/sc_wadd_param.md
SC_WADD_PARAM -- requirements
Module: sc_wadd_param

Interface
- REQ-001: Parameter N, default 12, is the binary and random-number width; one run lasts 2^N cycles.
- REQ-002: Parameter TAPS, default 19, is the number of weighted input channels.
- REQ-003: One clock; reset is asynchronous and active-high.
- REQ-004: clock  in  1  rising-edge system clock.
- REQ-005: reset  in  1  asynchronous active-high reset.
- REQ-006: start  in  1  begin or restart a run.
- REQ-007: in  in  TAPS x N  binary tap values, held stable for the whole run.
- REQ-008: rng_y  in  N  random number for stochastic-number generation.
- REQ-009: rng_sel  in  N  random number for tap selection.
- REQ-010: cfg_we  in  1  write strobe for the weight table.
- REQ-011: cfg_addr  in  clog2(TAPS)  index of the weight-table entry.
- REQ-012: cfg_cdf  in  N  cumulative-weight threshold for that entry.
- REQ-013: cfg_sign  in  1  negation flag for that entry.
- REQ-014: out  out  N+1  ones count of the run.
- REQ-015: done  out  1  one-cycle pulse when out is final.
- REQ-016: busy  out  1  high while in RUN.

Function
- REQ-017: FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after 2^N accumulate cycles.
  - DONE -> IDLE unconditionally, or DONE -> RUN if start is high.
- REQ-018: Per-tap stochastic bit sn[i] = (in[i] > rng_y), unsigned compare.
- REQ-019: xb[i] = sn[i] XOR sign[i].
- REQ-020: Selected tap = lowest i with rng_sel < cdf[i]; if no entry matches, tap TAPS-1.
- REQ-021: In each RUN cycle, out increments by xb[selected], evaluated from that cycle's inputs.
- REQ-022: A run-length counter of N+1 bits counts RUN cycles; RUN exits when it reaches 2^N; out width prevents overflow (maximum 2^N).
- REQ-023: Run timing:
  - start sampled at edge k clears out and the counter.
  - Accumulation occurs on edges k+1 .. k+2^N.
  - done is high for the cycle after edge k+2^N+1.
- REQ-024: out holds its final value after DONE until the next start.
- REQ-025: start during RUN restarts: out=0, counter=0, state stays RUN.
- REQ-026: cfg_we applies at the clock edge when state is IDLE or DONE; cfg_we during RUN is ignored; cfg_addr >= TAPS is ignored.
- REQ-027: The cdf table need not be monotonic; the lowest-index-match rule governs selection.

Reset
- REQ-028: Reset forces state IDLE, out=0, done=0, busy=0, counter=0, every cdf[i]=0, every sign[i]=0.
- REQ-029: Reset asserted mid-run aborts the run immediately; no done pulse is issued.

Configuration
- REQ-030: With SC_SIGN_EN defined, the sign[] storage and the XOR per REQ-019 are built.
- REQ-031: Without SC_SIGN_EN, xb[i]=sn[i]; cfg_sign is ignored and no sign storage is built.

Structure
- REQ-032: Package sc_fir_pkg holds:
  - default N and TAPS;
  - the FSM state enum (IDLE/RUN/DONE);
  - a function for the run length 2^N.
- REQ-033: Sub-module sc_cdf_select, purely combinational, holds the threshold compare and lowest-index priority select; it takes TAPS, N, cdf[] and rng_sel, and returns the tap index.

Verification (bench N=4, TAPS=4, SC_SIGN_EN defined unless stated)
- REQ-034: All cdf=15, signs=0, in all 15, rng_y=0, rng_sel=0 -> out=16, with done 18 cycles after start is sampled.
- REQ-035: cdf={8,16-wrap->15,15,15}, in={1,0,0,0}, rng_y=0, rng_sel sweeps 0..15 -> tap 0 for sel<8 -> out=8.
- REQ-036: Sign test, in all 0, sign[3]=1, cdf all 0 (falls to tap 3) -> out=16; rebuilt without SC_SIGN_EN -> out=0.
- REQ-037: start re-asserted at RUN cycle 5 -> out restarts from 0, done 18 cycles after the second start, with no done for the first run.
- REQ-038: cfg_we during RUN writes cdf[0]=0 -> table is unchanged after done; the same write in IDLE takes effect.
- REQ-039: reset pulsed mid-run -> out=0, busy=0, done never pulses, cdf all 0.
